// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// ALU execute unit with a one-entry registered output; optional iterative shifter (macro ALU_EXEC_SHIFT_EN).
// Latency: 1 cycle for non-shift codes; shift by N takes N+1 cycles (N=0 bypasses the shifter).
// Backpressure: in_ready drops while shifting or while a held result is not being taken; result holds until out_ready.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Negative,
    output logic        Carry,
    output logic        Overflow,
    output logic        illegal
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic        accept, take;
    logic [32:0] sum, diff;
    logic [31:0] res;
    logic        alu_c, alu_v, alu_ill, is_shift;

`ifdef ALU_EXEC_SHIFT_EN
    logic [31:0] sh_val, sh_nxt;
    logic [4:0]  sh_cnt;
    logic [1:0]  sh_op;
    logic        sh_done;
`endif

    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;

    assign sum  = {1'b0, SrcA} + {1'b0, SrcB};
    assign diff = {1'b0, SrcA} - {1'b0, SrcB};

    always_comb begin
        res      = 32'd0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (ALUControl)
            3'b000: begin
                res   = sum[31:0];
                alu_c = sum[32];
                alu_v = (SrcA[31] == SrcB[31]) && (sum[31] != SrcA[31]);
            end
            3'b001: begin
                res   = diff[31:0];
                alu_c = ~diff[32];  // no borrow means A >= B unsigned
                alu_v = (SrcA[31] != SrcB[31]) && (diff[31] != SrcA[31]);
            end
            3'b010: res = SrcA & SrcB;
            3'b011: res = SrcA | SrcB;
            3'b101: res = {31'd0, $signed(SrcA) < $signed(SrcB)};
`ifdef ALU_EXEC_SHIFT_EN
            3'b100, 3'b110, 3'b111: begin
                // zero-amount shifts skip the FSM and return the operand at latency 1
                if (SrcB[4:0] == 5'd0) res = SrcA;
                else                   is_shift = 1'b1;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef ALU_EXEC_SHIFT_EN
        sh_done   = 1'b0;
`endif
        case (state)
            IDLE: if (accept && is_shift) state_nxt = SHIFT;
            SHIFT: begin
`ifdef ALU_EXEC_SHIFT_EN
                if (sh_cnt == 5'd0 && (!out_valid || out_ready)) begin
                    sh_done   = 1'b1;
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    always_comb begin
        case (sh_op)
            2'b00:   sh_nxt = {sh_val[30:0], 1'b0};
            2'b10:   sh_nxt = {1'b0, sh_val[31:1]};
            default: sh_nxt = {sh_val[31], sh_val[31:1]};
        endcase
    end

    // counter holds remaining shifts minus one, so the final shift and the output load share an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_val <= 32'd0;
            sh_cnt <= 5'd0;
            sh_op  <= 2'd0;
        end else if (accept && is_shift) begin
            sh_val <= SrcA;
            sh_cnt <= SrcB[4:0] - 5'd1;
            sh_op  <= ALUControl[1:0];
        end else if (state == SHIFT && sh_cnt != 5'd0) begin
            sh_val <= sh_nxt;
            sh_cnt <= sh_cnt - 5'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            Result    <= 32'd0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !is_shift) begin
            out_valid <= 1'b1;
            Result    <= res;
            Zero      <= (res == 32'd0);
            Negative  <= res[31];
            Carry     <= alu_c;
            Overflow  <= alu_v;
            illegal   <= alu_ill;
`ifdef ALU_EXEC_SHIFT_EN
        end else if (sh_done) begin
            out_valid <= 1'b1;
            Result    <= sh_nxt;
            Zero      <= (sh_nxt == 32'd0);
            Negative  <= sh_nxt[31];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            illegal   <= 1'b0;
`endif
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operation offered.
REQ-004 SHALL have port in_ready, output, 1, unit accepts operation this cycle.
REQ-005 SHALL have port ALUControl, input, 3, operation code from ALU decoder.
REQ-006 SHALL have ports SrcA and SrcB, input, 32 each, operands.
REQ-007 SHALL have port out_valid, output, 1, result registered and presented.
REQ-008 SHALL have port out_ready, input, 1, consumer takes result.
REQ-009 SHALL have port Result, output, 32, operation result.
REQ-010 SHALL have ports Zero, Negative, Carry, Overflow, output, 1 each, flags of Result.
REQ-011 SHALL have port illegal, output, 1, Result came from an unsupported code.

Function
REQ-012 Codes SHALL be: 000 add, 001 sub (A-B), 010 and, 011 or, 101 slt (signed, Result = {31'b0, A<B}).
REQ-013 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-014 in_ready SHALL equal (state==IDLE) & (!out_valid | out_ready), combinationally.
REQ-015 FSM SHALL have states IDLE and SHIFT; non-shift codes stay in IDLE.
REQ-016 Non-shift codes SHALL give out_valid with Result in the cycle after acceptance (latency 1).
REQ-017 Result, flags and illegal SHALL hold stable while out_valid & !out_ready.
REQ-018 out_valid SHALL clear after a transfer out unless a new result loads in the same edge.
REQ-019 Simultaneous transfer out and transfer in SHALL overwrite the output register with no bubble.
REQ-020 Zero SHALL be (Result==0); Negative SHALL be Result[31].
REQ-021 Add: Carry = bit 32 of 33-bit sum; Overflow = signed overflow.
REQ-022 Sub: Carry = 1 when A >= B unsigned (no borrow); Overflow = signed overflow.
REQ-023 and, or, slt, shifts: Carry = 0, Overflow = 0.
REQ-024 Unsupported codes SHALL give Result 0, Zero 1, illegal 1 at latency 1; illegal SHALL be 0 otherwise.
REQ-025 Arithmetic SHALL be 32-bit modulo 2^32; no saturation.

Reset
REQ-026 rst low SHALL force state IDLE, out_valid 0, Result 0, all flags 0, illegal 0, shift counter 0, immediately.
REQ-027 Reset mid-SHIFT SHALL discard the operation; no result is produced after release.
REQ-028 First acceptance SHALL be possible on the first rising edge with rst high.

Configuration
REQ-029 Macro ALU_EXEC_SHIFT_EN SHALL enable iterative shifts: 100 sll, 110 srl, 111 sra, amount SrcB[4:0].
REQ-030 With the macro, acceptance of a shift SHALL load the operand and amount and enter SHIFT; in_ready is 0 in SHIFT.
REQ-031 In SHIFT the operand SHALL shift one bit per cycle and the counter decrements; at counter 0 the result loads and state returns to IDLE.
REQ-032 Shift latency SHALL be amount+1 cycles from acceptance to out_valid (amount 0 -> 1 cycle, passes operand unchanged).
REQ-033 sra SHALL replicate bit 31; sll/srl SHALL fill zeros.
REQ-034 Without the macro, codes 100, 110, 111 SHALL be treated as unsupported (REQ-024) and SHIFT SHALL never be entered.

Verification
REQ-035 add 0xFFFFFFFF + 0x00000001 -> Result 0, Zero 1, Carry 1, Overflow 0, out_valid one cycle after acceptance.
REQ-036 sub 0x80000000 - 0x00000001 -> Result 0x7FFFFFFF, Overflow 1, Carry 1, Negative 0.
REQ-037 slt A=0xFFFFFFFE, B=0x00000001 -> Result 1; and 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
REQ-038 out_ready held 0 for 3 cycles with out_valid 1 -> in_ready 0, Result stable; out_ready 1 with in_valid 1 -> back-to-back transfer, no bubble.
REQ-039 ALU_EXEC_SHIFT_EN defined: sra 0x80000000 by 4 -> Result 0xF8000000 after 5 cycles, in_ready 0 throughout; undefined: same stimulus -> Result 0, illegal 1 after 1 cycle.
REQ-040 rst asserted 2 cycles into a shift of amount 10 -> out_valid 0, state IDLE; after release no result emerges and new add accepted on the first edge.
